// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline hazard unit: stall/flush/forward control, a small
//             status FSM, saturating event counters and a deadlock detector.
//  Option   : HAZARD_FORWARD_EN enables EX/MEM and MEM/WB operand forwarding.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [4:0]  dx_rs,
    input  logic [4:0]  dx_rt,
    input  logic [4:0]  dx_rd,
    input  logic [4:0]  xm_rd,
    input  logic [4:0]  mw_rd,
    input  logic        dx_regwrite,
    input  logic        xm_regwrite,
    input  logic        mw_regwrite,
    input  logic        dx_memread,
    input  logic        xm_memread,
    input  logic        dx_jump,
    input  logic        xm_branch,
    output logic        pc_stall,
    output logic        fd_stall,
    output logic        dx_bubble,
    output logic        fd_flush,
    output logic        dx_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic        deadlock
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_STALL  = 2'b01,
        ST_FLUSH  = 2'b10,
        ST_UNUSED = 2'b11
    } state_t;

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;
    localparam logic [2:0]  C_RUN_MAX = 3'd7;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic [2:0]  r_run_cnt;
    logic        r_deadlock;
    logic        w_hazard;
    logic        w_stall;
    logic        w_flush_any;

    function automatic logic src_match(input logic [4:0] src, input logic src_used,
                                       input logic wr, input logic [4:0] rd);
        return src_used && wr && (rd != 5'd0) && (rd == src);
    endfunction

    logic w_dx_hit;
    assign w_dx_hit = src_match(id_rs, id_use_rs, dx_regwrite, dx_rd) ||
                      src_match(id_rt, id_use_rt, dx_regwrite, dx_rd);

`ifdef HAZARD_FORWARD_EN
    // Only a load in EX cannot be forwarded in time; everything else is bypassed.
    assign w_hazard = dx_memread && w_dx_hit;

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (xm_regwrite && !xm_memread && (xm_rd != 5'd0) && (xm_rd == dx_rs))
            fwd_a = 2'b10;
        else if (mw_regwrite && (mw_rd != 5'd0) && (mw_rd == dx_rs))
            fwd_a = 2'b01;
        if (xm_regwrite && !xm_memread && (xm_rd != 5'd0) && (xm_rd == dx_rt))
            fwd_b = 2'b10;
        else if (mw_regwrite && (mw_rd != 5'd0) && (mw_rd == dx_rt))
            fwd_b = 2'b01;
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{dx_rs, dx_rt, xm_memread, dx_memread};

    assign w_hazard = w_dx_hit ||
                      src_match(id_rs, id_use_rs, xm_regwrite, xm_rd) ||
                      src_match(id_rt, id_use_rt, xm_regwrite, xm_rd) ||
                      src_match(id_rs, id_use_rs, mw_regwrite, mw_rd) ||
                      src_match(id_rt, id_use_rt, mw_regwrite, mw_rd);
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    // Control-flow redirects override stalls: the stalled instruction is squashed anyway.
    always_comb begin
        fd_flush    = xm_branch || dx_jump;
        dx_flush    = xm_branch;
        w_stall     = w_hazard && !xm_branch && !dx_jump;
        w_flush_any = fd_flush || dx_flush;
        pc_stall    = w_stall;
        fd_stall    = w_stall;
        dx_bubble   = w_stall;
        w_state_nxt = ST_RUN;
        case (r_state)
            ST_UNUSED: w_state_nxt = ST_RUN;
            default: begin
                if (w_flush_any)
                    w_state_nxt = ST_FLUSH;
                else if (w_stall)
                    w_state_nxt = ST_STALL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
            r_run_cnt   <= 3'd0;
            r_deadlock  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_stall && (r_stall_cnt != C_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_flush_any && (r_flush_cnt != C_CNT_MAX))
                r_flush_cnt <= r_flush_cnt + 16'd1;
            if (!w_stall)
                r_run_cnt <= 3'd0;
            else if (r_run_cnt != C_RUN_MAX)
                r_run_cnt <= r_run_cnt + 3'd1;
            // Eighth consecutive stall cycle marks the pipeline as wedged.
            if (w_stall && (r_run_cnt == C_RUN_MAX))
                r_deadlock <= 1'b1;
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign deadlock  = r_deadlock;

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, single clock, all state updates on rising edge.
REQ-002 rst, input, 1, asynchronous active-high reset.
REQ-003 id_rs / id_rt, input, 5 each, source registers of the instruction held in the IF/ID register.
REQ-004 id_use_rs / id_use_rt, input, 1 each, the IF/ID instruction reads that source.
REQ-005 dx_rs / dx_rt, input, 5 each, source registers of the ID/EX instruction.
REQ-006 dx_rd, xm_rd, mw_rd, input, 5 each, destination register per stage.
REQ-007 dx_regwrite, xm_regwrite, mw_regwrite, dx_memread, xm_memread, input, 1 each, stage control bits.
REQ-008 dx_jump, input, 1, jump in ID/EX; xm_branch, input, 1, taken branch in EX/MEM.
REQ-009 pc_stall, fd_stall, dx_bubble, output, 1 each, hold PC, hold IF/ID, zero ID/EX controls.
REQ-010 fd_flush, dx_flush, output, 1 each, squash IF/ID or ID/EX contents.
REQ-011 fwd_a / fwd_b, output, 2 each, ALU operand select: 00 register file, 01 MEM/WB, 10 EX/MEM.
REQ-012 state, output, 2, registered FSM state; stall_cnt / flush_cnt, output, 16 each; deadlock, output, 1.

Function
REQ-013 A source SHALL match a stage when that stage has regwrite=1, rd!=0, rd equals the source, and the source's use bit is 1.
REQ-014 load_use SHALL be 1 when a used IF/ID source matches the ID/EX stage and dx_memread=1.
REQ-015 The hazard term SHALL be load_use when forwarding is enabled, else any match in ID/EX, EX/MEM or MEM/WB (Configuration).
REQ-016 Priority SHALL be xm_branch > dx_jump > hazard, and the outputs SHALL be combinational in the same cycle.
REQ-017 On xm_branch=1, fd_flush=dx_flush=1 and all stall outputs SHALL be 0.
REQ-018 On dx_jump=1 without xm_branch, fd_flush=1, dx_flush=0 and stall outputs SHALL be 0.
REQ-019 On hazard with no flush, pc_stall=fd_stall=dx_bubble=1.
REQ-020 FSM states SHALL be RUN=00, STALL=01, FLUSH=10 (11 unused; it SHALL go to RUN next cycle).
REQ-021 FSM next state SHALL be FLUSH if any flush is asserted, else STALL if stalling, else RUN.
REQ-022 stall_cnt SHALL increment on each stall cycle and saturate at 0xFFFF.
REQ-023 flush_cnt SHALL increment on each cycle with any flush asserted and saturate at 0xFFFF.
REQ-024 An internal 3-bit run counter SHALL count consecutive stall cycles and clear on any non-stall cycle.
REQ-025 When a stall cycle occurs with the run counter at 7, deadlock SHALL set and stay set (sticky) until reset.

Reset
REQ-026 rst=1 SHALL force, asynchronously: state=RUN, stall_cnt=0, flush_cnt=0, run counter=0, deadlock=0.
REQ-027 Combinational outputs SHALL follow their inputs during reset; with all inputs 0 they SHALL all be 0.
REQ-028 Reset asserted mid-stall SHALL drop the counters immediately; counting SHALL resume on the first edge after deassertion.

Configuration
REQ-029 With macro HAZARD_FORWARD_EN defined:
- fwd_a / fwd_b SHALL select 10 on an EX/MEM match with xm_memread=0.
- Otherwise they SHALL select 01 on a MEM/WB match, else 00 (dx_rs / dx_rt compared, use bits ignored).
- Only load_use SHALL stall.
REQ-030 Without HAZARD_FORWARD_EN:
- fwd_a = fwd_b = 00 at all times.
- A RAW match against any of the three later stages SHALL stall.

Verification
REQ-031 Forwarding on:
- Stimulus: dx_memread=1, dx_regwrite=1, dx_rd=5, id_rs=5, id_use_rs=1.
- Response: pc_stall=fd_stall=dx_bubble=1; next edge state=01, stall_cnt=1.
REQ-032 Forwarding on:
- Stimulus: xm_regwrite=1, xm_rd=8, mw_regwrite=1, mw_rd=8, dx_rs=8.
- Response: fwd_a=10; with xm_regwrite=0, fwd_a=01.
REQ-033 Stimulus: xm_branch=1 and the REQ-031 hazard together.
- Response: fd_flush=dx_flush=1, stalls=0, next state=10, flush_cnt=1.
REQ-034 Stimulus: dx_jump=1 for 1 cycle.
- Response: fd_flush=1, dx_flush=0, state=10 then 00.
REQ-035 Stimulus: hazard held for 8 consecutive cycles.
- Response: deadlock=1 after the 8th edge; it stays 1 after the hazard clears until rst.
REQ-036 Forwarding off:
- Stimulus: mw_regwrite=1, mw_rd=3, id_rt=3, id_use_rt=1.
- Response: stall=1, fwd_b=00.
- Stimulus: mw_rd=0.
- Response: no stall.
